// File: rtl/arm_cond_pkg.sv
// Shared types for ARM condition evaluation: condition codes, NZCV flag layout
// and the branch-resolution FSM state encoding.
package arm_cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } brst_e;

    function automatic nzcv_t nzcv_unpack(input logic [3:0] raw);
        nzcv_t f;
        f.n = raw[FLAG_N];
        f.z = raw[FLAG_Z];
        f.c = raw[FLAG_C];
        f.v = raw[FLAG_V];
        return f;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: (cond, NZCV) -> condition holds.
// Shared by the branch unit and, later, conditional-select.
module cond_eval
    import arm_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       cond_true
);

    nzcv_t f_s;

    assign f_s = nzcv_unpack(nzcv);

    // Condition decode; AL and NV are both unconditional on this core.
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            EQ:      cond_true = f_s.z;
            NE:      cond_true = ~f_s.z;
            HS:      cond_true = f_s.c;
            LO:      cond_true = ~f_s.c;
            MI:      cond_true = f_s.n;
            PL:      cond_true = ~f_s.n;
            VS:      cond_true = f_s.v;
            VC:      cond_true = ~f_s.v;
            HI:      cond_true = f_s.c & ~f_s.z;
            LS:      cond_true = ~f_s.c | f_s.z;
            GE:      cond_true = (f_s.n == f_s.v);
            LT:      cond_true = (f_s.n != f_s.v);
            GT:      cond_true = ~f_s.z & (f_s.n == f_s.v);
            LE:      cond_true = f_s.z | (f_s.n != f_s.v);
            AL:      cond_true = 1'b1;
            NV:      cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_unit.sv
// NZCV flag register plus B.cond / CBZ resolution in ID with IF flush and flag-hazard stall.
// Optional feature: define FLAG_FWD_EN to forward EX flags into ID and never stall.
module cond_branch_unit
    import arm_cond_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ex_valid,
    input  logic       ex_set_flags,
    input  logic [3:0] ex_flags,
    input  logic       id_valid,
    input  logic       id_is_bcond,
    input  logic       id_is_cbz,
    input  logic [3:0] id_cond,
    input  logic       id_rt_zero,
    output logic [3:0] flags_q,
    output logic       br_taken,
    output logic       flush_if,
    output logic       hazard_stall
);

    localparam int FC_EFF = (FLUSH_CYCLES < 1) ? 1 : ((FLUSH_CYCLES > 3) ? 3 : FLUSH_CYCLES);
    localparam int CNT_W  = $clog2(FC_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FC_EFF - 1);

    brst_e            state_r;
    brst_e            state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;

    logic       flag_wr_s;
    logic       cbz_s;
    logic       bcond_s;
    logic       hazard_s;
    logic [3:0] eval_flags_s;
    logic       bcond_true_s;
    logic       taken_s;
    logic       br_s;
    logic       flush_s;
    logic       stall_s;

    assign flag_wr_s = ex_valid & ex_set_flags;
    // CBZ wins when decode asserts both branch kinds.
    assign cbz_s     = id_valid & id_is_cbz;
    assign bcond_s   = id_valid & id_is_bcond & ~id_is_cbz;

    // Flag source for B.cond and the read-after-write flag hazard.
    always_comb begin
        eval_flags_s = flags_q;
        hazard_s     = 1'b0;
`ifdef FLAG_FWD_EN
        if (flag_wr_s) begin
            eval_flags_s = ex_flags;
        end else begin
            eval_flags_s = flags_q;
        end
`else
        if (bcond_s && flag_wr_s) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
`endif
    end

    cond_eval u_cond_eval (
        .cond      (id_cond),
        .nzcv      (eval_flags_s),
        .cond_true (bcond_true_s)
    );

    assign taken_s = cbz_s ? id_rt_zero : (bcond_s & bcond_true_s);

    // Architectural NZCV register.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (flag_wr_s) begin
            flags_q <= ex_flags;
        end
    end

    // FSM state and flush counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state logic and pipeline-control outputs.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        br_s       = 1'b0;
        flush_s    = 1'b0;
        stall_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (hazard_s) begin
                    stall_s    = 1'b1;
                    state_nx_s = STALL;
                end else if (taken_s) begin
                    br_s       = 1'b1;
                    flush_s    = 1'b1;
                    cnt_nx_s   = CNT_LOAD;
                    state_nx_s = FLUSH;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            STALL: begin
                // The stalled EX write has landed; an upstream-squashed ID simply drops out.
                if (taken_s) begin
                    br_s       = 1'b1;
                    flush_s    = 1'b1;
                    cnt_nx_s   = CNT_LOAD;
                    state_nx_s = FLUSH;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FLUSH: begin
                // ID here holds an already-squashed instruction, so branches are ignored.
                if (cnt_r != {CNT_W{1'b0}}) begin
                    flush_s  = 1'b1;
                    cnt_nx_s = cnt_r - CNT_W'(1);
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
        if (reset) begin
            br_s    = 1'b0;
            flush_s = 1'b0;
            stall_s = 1'b0;
        end else begin
            stall_s = stall_s;
        end
    end

    assign br_taken     = br_s;
    assign flush_if     = flush_s;
    assign hazard_stall = stall_s;

endmodule
